// File: rtl/trans_layer_n.sv
// trans_layer_n: N-channel transaction layer.
// Takes one word per cycle on a single input port and steers it into one of
// CHANNELS first-word-fall-through FIFOs, chosen by the word's top CH_BITS bits.
// A control FSM (RESET/INIT/IDLE/ACTIVE/ERROR) latches the almost-full and
// almost-empty thresholds, clears all state in INIT and makes protocol errors sticky.
// A statistics bank counts the pops on each channel and the accepted pushes.
//
// Ports:
//   clk, reset (async, active-high)
//   init, th_almost_full, th_almost_empty - control and threshold latching
//   push, data_in, in_ready               - input port with backpressure
//   pop, data_out, out_valid              - per-channel FWFT read side
//   almost_full, almost_empty             - per-channel flags from registered counts
//   req, idx, data_out_cont, valid_cont   - statistics readout (IDLE only)
//   idle, error                           - FSM status
module trans_layer_n #(
    parameter int unsigned DATA_SIZE = 12,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_SIZE  = 5,
    localparam int unsigned CH_BITS  = $clog2(CHANNELS),
    localparam int unsigned TH_SIZE  = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init,
    input  logic [TH_SIZE-1:0]            th_almost_full,
    input  logic [TH_SIZE-1:0]            th_almost_empty,
    input  logic                          push,
    input  logic [DATA_SIZE-1:0]          data_in,
    output logic                          in_ready,
    input  logic [CHANNELS-1:0]           pop,
    output logic [CHANNELS*DATA_SIZE-1:0] data_out,
    output logic [CHANNELS-1:0]           out_valid,
    output logic [CHANNELS-1:0]           almost_full,
    output logic [CHANNELS-1:0]           almost_empty,
    input  logic                          req,
    input  logic [CH_BITS:0]              idx,
    output logic [CNT_SIZE-1:0]           data_out_cont,
    output logic                          valid_cont,
    output logic                          idle,
    output logic                          error
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {StReset, StInit, StIdle, StActive, StError} state_e;

    state_e state_q, state_d;

    logic [DATA_SIZE-1:0] mem_q [CHANNELS][DEPTH];
    logic [PTR_W-1:0]     rd_q [CHANNELS];
    logic [PTR_W-1:0]     rd_d [CHANNELS];
    logic [PTR_W-1:0]     wr_q [CHANNELS];
    logic [PTR_W-1:0]     wr_d [CHANNELS];
    logic [TH_SIZE-1:0]   cnt_q [CHANNELS];
    logic [TH_SIZE-1:0]   cnt_d [CHANNELS];
    logic [CNT_SIZE-1:0]  pop_cnt_q [CHANNELS];
    logic [CNT_SIZE-1:0]  pop_cnt_d [CHANNELS];
    logic [CNT_SIZE-1:0]  push_cnt_q, push_cnt_d;
    logic [TH_SIZE-1:0]   th_af_q, th_af_d, th_ae_q, th_ae_d;
    logic [CNT_SIZE-1:0]  cont_q, cont_d;
    logic                 valid_cont_q, valid_cont_d;

    logic [CH_BITS-1:0]   dest;
    logic                 op_state;
    logic [CHANNELS-1:0]  full;
    logic [CHANNELS-1:0]  nonempty;
    logic [CHANNELS-1:0]  wr_sel;
    logic [CHANNELS-1:0]  pop_ok;
    logic                 push_ok;
    logic                 err_evt;
    logic                 all_empty_d;

    assign dest     = data_in[DATA_SIZE-1 -: CH_BITS];
    assign op_state = (state_q == StIdle) || (state_q == StActive);

    always_comb begin
        full     = '0;
        nonempty = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            full[i]     = (cnt_q[i] == TH_SIZE'(DEPTH));
            nonempty[i] = (cnt_q[i] != '0);
        end
    end

    // in_ready looks only at the registered count, so a same-cycle pop on a
    // full channel does not make room for the push.
    assign in_ready = op_state && !full[dest];
    assign push_ok  = push && in_ready;
    assign pop_ok   = op_state ? (pop & nonempty) : '0;
    assign err_evt  = op_state && ((push && !in_ready) || (|(pop & ~nonempty)));

    always_comb begin
        wr_sel = '0;
        if (push_ok) begin
            wr_sel[dest] = 1'b1;
        end
    end

    // FIFO pointers, occupancy and statistics counters.
    always_comb begin
        push_cnt_d  = push_cnt_q;
        all_empty_d = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            rd_d[i]      = rd_q[i];
            wr_d[i]      = wr_q[i];
            cnt_d[i]     = cnt_q[i];
            pop_cnt_d[i] = pop_cnt_q[i];
        end
        if (state_q == StInit) begin
            push_cnt_d = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rd_d[i]      = '0;
                wr_d[i]      = '0;
                cnt_d[i]     = '0;
                pop_cnt_d[i] = '0;
            end
        end else begin
            if (push_ok) begin
                push_cnt_d = push_cnt_q + CNT_SIZE'(1);
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_sel[i]) begin
                    wr_d[i] = wr_q[i] + PTR_W'(1);
                end
                if (pop_ok[i]) begin
                    rd_d[i]      = rd_q[i] + PTR_W'(1);
                    pop_cnt_d[i] = pop_cnt_q[i] + CNT_SIZE'(1);
                end
                if (wr_sel[i] && !pop_ok[i]) begin
                    cnt_d[i] = cnt_q[i] + TH_SIZE'(1);
                end else if (!wr_sel[i] && pop_ok[i]) begin
                    cnt_d[i] = cnt_q[i] - TH_SIZE'(1);
                end
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (cnt_d[i] != '0) begin
                all_empty_d = 1'b0;
            end
        end
    end

    // Control FSM; a protocol error overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:  state_d = StInit;
            StInit:   if (!init) state_d = StIdle;
            StIdle: begin
                if (init) begin
                    state_d = StInit;
                end else if (push_ok) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (init) begin
                    state_d = StInit;
                end else if (all_empty_d && !push_ok) begin
                    state_d = StIdle;
                end
            end
            StError:  if (init) state_d = StInit;
            default:  state_d = StReset;
        endcase
        if (err_evt) begin
            state_d = StError;
        end
    end

    always_comb begin
        th_af_d = th_af_q;
        th_ae_d = th_ae_q;
        if (state_q == StInit) begin
            th_af_d = th_almost_full;
            th_ae_d = th_almost_empty;
        end
    end

    // Statistics readout samples the counters before this edge's increments.
    always_comb begin
        valid_cont_d = 1'b0;
        cont_d       = '0;
        if ((state_q == StIdle) && req) begin
            valid_cont_d = 1'b1;
            if (idx < (CH_BITS+1)'(CHANNELS)) begin
                cont_d = pop_cnt_q[idx[CH_BITS-1:0]];
            end else if (idx == (CH_BITS+1)'(CHANNELS)) begin
                cont_d = push_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StReset;
            push_cnt_q   <= '0;
            th_af_q      <= TH_SIZE'(DEPTH - 1);
            th_ae_q      <= TH_SIZE'(1);
            cont_q       <= '0;
            valid_cont_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                rd_q[i]      <= '0;
                wr_q[i]      <= '0;
                cnt_q[i]     <= '0;
                pop_cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            push_cnt_q   <= push_cnt_d;
            th_af_q      <= th_af_d;
            th_ae_q      <= th_ae_d;
            cont_q       <= cont_d;
            valid_cont_q <= valid_cont_d;
            for (int i = 0; i < CHANNELS; i++) begin
                rd_q[i]      <= rd_d[i];
                wr_q[i]      <= wr_d[i];
                cnt_q[i]     <= cnt_d[i];
                pop_cnt_q[i] <= pop_cnt_d[i];
            end
        end
    end

    // Storage needs no reset: an empty FIFO masks its head to zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_sel[i]) begin
                mem_q[i][wr_q[i]] <= data_in;
            end
        end
    end

    always_comb begin
        data_out     = '0;
        almost_full  = '0;
        almost_empty = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            data_out[i*DATA_SIZE +: DATA_SIZE] = nonempty[i] ? mem_q[i][rd_q[i]] : '0;
            almost_full[i]  = (cnt_q[i] >= th_af_q);
            almost_empty[i] = (cnt_q[i] <= th_ae_q);
        end
    end

    assign out_valid     = nonempty;
    assign data_out_cont = cont_q;
    assign valid_cont    = valid_cont_q;
    assign idle          = (state_q == StIdle);
    assign error         = (state_q == StError);

endmodule
